// File: rtl/spi_master_engine.sv
// Byte-oriented SPI master shift engine; SCLK comes from a half-period clock-enable counter.
// Optional macro SPI_MODE_SEL_EN adds cpol/cpha inputs; the default build is fixed mode 0.
module spi_master_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            prescale,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
`ifdef SPI_MODE_SEL_EN
    input  logic                  cpol,
    input  logic                  cpha,
`endif
    output logic                  cs_n
);

    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, FINISH} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [2:0]            presc_q, presc_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  sclk_q, sclk_d;

    logic                  accept, active, tc, lead, trail, last_edge;
    logic [CNT_WIDTH-1:0]  half_m1;
    logic                  mode_cpol, mode_cpha;

    // FINISH also accepts start so back-to-back frames see a single cs_n high cycle.
    assign accept    = start && (state_q == IDLE || state_q == FINISH);
    assign active    = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
    assign half_m1   = (CNT_WIDTH'(1) << presc_q) - CNT_WIDTH'(1);
    assign tc        = (cnt_q == half_m1);
    assign lead      = (state_q == SHIFT) && tc && !sclk_q;
    assign trail     = (state_q == SHIFT) && tc && sclk_q;
    assign last_edge = trail && (bit_cnt_q == BW'(DATA_WIDTH));

`ifdef SPI_MODE_SEL_EN
    logic cpol_q, cpol_d, cpha_q, cpha_d;

    always_comb begin
        cpol_d = cpol_q;
        cpha_d = cpha_q;
        if (accept) begin
            cpol_d = cpol;
            cpha_d = cpha;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
        end else begin
            cpol_q <= cpol_d;
            cpha_q <= cpha_d;
        end
    end

    assign mode_cpol = cpol_q;
    assign mode_cpha = cpha_q;
`else
    assign mode_cpol = 1'b0;
    assign mode_cpha = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETUP;
            SETUP:   if (tc) state_d = SHIFT;
            SHIFT:   if (last_edge) state_d = HOLD;
            HOLD:    if (tc) state_d = FINISH;
            FINISH:  state_d = start ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = active;
        cs_n    = !active;
        done    = (state_q == FINISH);
        sclk    = sclk_q ^ mode_cpol;
        rx_data = rx_data_q;
        mosi    = 1'b0;
        // With cpha=1 the first bit only appears at the first leading edge.
        if (active && !(mode_cpha && bit_cnt_q == '0)) begin
            mosi = shift_q[DATA_WIDTH-1];
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        presc_d    = presc_q;
        shift_d    = shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        bit_cnt_d  = bit_cnt_q;
        sclk_d     = sclk_q;
        if (accept) begin
            presc_d    = prescale;
            shift_d    = tx_data;
            rx_shift_d = '0;
            cnt_d      = '0;
            bit_cnt_d  = '0;
            sclk_d     = 1'b0;
        end else if (active) begin
            cnt_d = tc ? '0 : cnt_q + CNT_WIDTH'(1);
            if (lead) begin
                sclk_d    = 1'b1;
                bit_cnt_d = bit_cnt_q + BW'(1);
                if (!mode_cpha) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso};
                end else if (bit_cnt_q != '0) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
            if (trail) begin
                sclk_d = 1'b0;
                if (mode_cpha) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso};
                end else if (!last_edge) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
            if (state_q == HOLD && tc) begin
                rx_data_d = rx_shift_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            presc_q    <= '0;
            shift_q    <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            presc_q    <= presc_d;
            shift_q    <= shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
        end
    end

endmodule

// File: tb/tb_spi_master_engine.sv
// Directed bench for spi_master_engine: vector table of single frames plus
// hand-written back-to-back, mid-transfer disturbance and reset-abort sequences.
module tb_spi_master_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] prescale;
    logic       start;
    logic [7:0] tx_data;
    logic       busy, done, sclk, mosi, cs_n;
    logic [7:0] rx_data;
    logic       miso_tie;
    bit         miso_loop;
    wire logic  miso;

    int tests = 0;
    int fails = 0;

    assign miso = miso_loop ? mosi : miso_tie;

    always #5 clk = ~clk;

    spi_master_engine #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .prescale (prescale),
        .start    (start),
        .tx_data  (tx_data),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
`ifdef SPI_MODE_SEL_EN
        .cpol     (1'b0),
        .cpha     (1'b0),
`endif
        .cs_n     (cs_n)
    );

    typedef struct {
        logic [2:0] p;
        logic [7:0] tx;
        int         miso_mode;  // 0 loopback, 1 tied high, 2 tied low
        logic [7:0] exp_rx;
        int         exp_lat;
        int         exp_hi;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call with start already driven for the accept edge; returns on the sample where done is seen.
    task automatic run_frame(input logic [7:0] mid_tx, input logic [2:0] mid_presc,
                             input bit glitch, input bit hold_start,
                             output int lat, output logic [7:0] bits, output int pulses,
                             output int hi_min, output int hi_max, output int cs_errs);
        int   hi_run;
        logic prev_sclk;
        lat = -1; bits = '0; pulses = 0; hi_min = 1000; hi_max = 0; cs_errs = 0;
        hi_run = 0; prev_sclk = 1'b0;
        for (int k = 1; k <= 2000; k++) begin
            tick();
            if (k == 1) begin
                if (!hold_start) start = 1'b0;
                tx_data  = mid_tx;
                prescale = mid_presc;
            end
            if (glitch) start = (k == 5);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (cs_n !== 1'b0 || busy !== 1'b1) cs_errs++;
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                pulses++;
                bits = {bits[6:0], mosi};
            end
            if (sclk === 1'b1) begin
                hi_run++;
            end else if (prev_sclk === 1'b1) begin
                if (hi_run < hi_min) hi_min = hi_run;
                if (hi_run > hi_max) hi_max = hi_run;
                hi_run = 0;
            end
            prev_sclk = sclk;
        end
    endtask

    initial begin
        int         lat, pulses, hi_min, hi_max, cs_errs, done_seen;
        logic [7:0] bits;

        vecs[0] = '{p: 3'd0, tx: 8'hA5, miso_mode: 0, exp_rx: 8'hA5, exp_lat: 19,  exp_hi: 1};
        vecs[1] = '{p: 3'd3, tx: 8'h3C, miso_mode: 1, exp_rx: 8'hFF, exp_lat: 145, exp_hi: 8};
        vecs[2] = '{p: 3'd1, tx: 8'h5A, miso_mode: 2, exp_rx: 8'h00, exp_lat: 37,  exp_hi: 2};
        vecs[3] = '{p: 3'd2, tx: 8'hC3, miso_mode: 0, exp_rx: 8'hC3, exp_lat: 73,  exp_hi: 4};
        vecs[4] = '{p: 3'd0, tx: 8'h81, miso_mode: 1, exp_rx: 8'hFF, exp_lat: 19,  exp_hi: 1};

        rst = 1'b1; start = 1'b0; prescale = '0; tx_data = '0; miso_tie = 1'b0; miso_loop = 1'b0;
        repeat (3) tick();
        check("reset busy", busy, 0);
        check("reset cs_n", cs_n, 1);
        check("reset sclk", sclk, 0);
        check("reset mosi", mosi, 0);
        check("reset done", done, 0);
        check("reset rx_data", rx_data, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            miso_loop = (vecs[i].miso_mode == 0);
            miso_tie  = (vecs[i].miso_mode == 1);
            prescale  = vecs[i].p;
            tx_data   = vecs[i].tx;
            start     = 1'b1;
            run_frame(vecs[i].tx, vecs[i].p, 1'b0, 1'b0, lat, bits, pulses, hi_min, hi_max, cs_errs);
            check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d rx_data", i), rx_data, vecs[i].exp_rx);
            check($sformatf("v%0d mosi bits", i), bits, vecs[i].tx);
            check($sformatf("v%0d sclk pulses", i), pulses, 8);
            check($sformatf("v%0d sclk hi min", i), hi_min, vecs[i].exp_hi);
            check($sformatf("v%0d sclk hi max", i), hi_max, vecs[i].exp_hi);
            check($sformatf("v%0d cs_n/busy in frame", i), cs_errs, 0);
            check($sformatf("v%0d cs_n at done", i), cs_n, 1);
            check($sformatf("v%0d busy at done", i), busy, 0);
            check($sformatf("v%0d mosi at done", i), mosi, 0);
            tick();
            check($sformatf("v%0d done one cycle", i), done, 0);
            check($sformatf("v%0d idle after", i), busy, 0);
            tick();
        end

        // Back-to-back: start held across done; second byte presented after the first accept.
        miso_loop = 1'b1;
        prescale  = 3'd0;
        tx_data   = 8'h01;
        start     = 1'b1;
        run_frame(8'h80, 3'd0, 1'b0, 1'b1, lat, bits, pulses, hi_min, hi_max, cs_errs);
        check("b2b f1 latency", lat, 19);
        check("b2b f1 bits", bits, 8'h01);
        check("b2b f1 rx_data", rx_data, 8'h01);
        check("b2b f1 cs_n gap", cs_n, 1);
        run_frame(8'h80, 3'd0, 1'b0, 1'b0, lat, bits, pulses, hi_min, hi_max, cs_errs);
        check("b2b f2 latency", lat, 19);
        check("b2b f2 bits", bits, 8'h80);
        check("b2b f2 rx_data", rx_data, 8'h80);
        check("b2b f2 cs_n/busy in frame", cs_errs, 0);
        tick();
        check("b2b no third frame", busy, 0);
        tick();

        // Mid-transfer start pulse plus tx_data/prescale changes must not disturb the frame.
        prescale = 3'd1;
        tx_data  = 8'hA5;
        start    = 1'b1;
        run_frame(8'h3C, 3'd3, 1'b1, 1'b0, lat, bits, pulses, hi_min, hi_max, cs_errs);
        check("mid latency", lat, 37);
        check("mid bits", bits, 8'hA5);
        check("mid rx_data", rx_data, 8'hA5);
        check("mid sclk hi max", hi_max, 2);
        tick();
        check("mid start ignored", busy, 0);
        tick();

        // Reset asserted at cycle 10 of a prescale=1 frame.
        prescale = 3'd1;
        tx_data  = 8'hF0;
        start    = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) start = 1'b0;
        end
        rst = 1'b1;
        tick();
        check("abort cs_n", cs_n, 1);
        check("abort sclk", sclk, 0);
        check("abort busy", busy, 0);
        check("abort mosi", mosi, 0);
        check("abort rx_data", rx_data, 0);
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 50; k++) begin
            if (done === 1'b1) done_seen++;
            tick();
        end
        check("abort no done", done_seen, 0);

        prescale = 3'd1;
        tx_data  = 8'h96;
        start    = 1'b1;
        run_frame(8'h96, 3'd1, 1'b0, 1'b0, lat, bits, pulses, hi_min, hi_max, cs_errs);
        check("post-abort latency", lat, 37);
        check("post-abort rx_data", rx_data, 8'h96);
        check("post-abort bits", bits, 8'h96);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
